// File: rtl/fp_mul_sched.sv
// Issue arbiter and credit-limited result FIFO for the shared 2-cycle pipelined FP multiplier.
// Round-robin grant, shadow pipe tracking live ops and their exception flags, writeback buffer.
module fp_mul_sched #(
    parameter int unsigned RV       = 64,
    parameter int unsigned LNCOMMIT = 6,
    parameter int unsigned NHART    = 1,
    parameter int unsigned LNHART   = 1,
    parameter int unsigned NREQ     = 2,
    parameter int unsigned LNREQ    = 1,
    parameter int unsigned FDEPTH   = 4,
    localparam int unsigned HW      = (NHART == 1) ? 1 : LNHART
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*LNCOMMIT-1:0] i_req_rd,
    input  logic [NREQ*HW-1:0]       i_req_hart,
    output logic [NREQ-1:0]          o_req_ack,
    output logic                     o_mul_start,
    output logic [LNREQ-1:0]         o_mul_sel,
    output logic [LNCOMMIT-1:0]      o_mul_rd,
    output logic [HW-1:0]            o_mul_hart,
    input  logic                     i_mul_exception,
    input  logic                     i_mul_valid,
    input  logic [RV-1:0]            i_mul_res,
    input  logic [LNCOMMIT-1:0]      i_mul_rd_out,
    input  logic [HW-1:0]            i_mul_hart_out,
    input  logic                     i_flush,
    output logic                     o_wb_req,
    output logic [RV-1:0]            o_wb_res,
    output logic [LNCOMMIT-1:0]      o_wb_rd,
    output logic [HW-1:0]            o_wb_hart,
    output logic                     o_wb_exception,
    input  logic                     i_wb_ack
);

    localparam int unsigned AW = $clog2(FDEPTH);

    logic [LNREQ-1:0]    r_rr;
    logic                r_s0_live;
    logic                r_s0_exc;
    logic                r_s1_live;
    logic                r_s1_exc;
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [AW:0]         r_count;

    logic [RV-1:0]       r_mem_res  [FDEPTH];
    logic [LNCOMMIT-1:0] r_mem_rd   [FDEPTH];
    logic [HW-1:0]       r_mem_hart [FDEPTH];
    logic                r_mem_exc  [FDEPTH];

    logic                w_grant_found;
    logic [LNREQ-1:0]    w_grant_idx;
    logic [LNREQ:0]      w_scan;
    logic [LNREQ:0]      w_rr_inc;
    logic [LNREQ-1:0]    w_rr_next;
    logic [AW+1:0]       w_used;
    logic                w_credit;
    logic                w_issue;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [AW:0]         w_count_next;

    // Scan from the lowest priority upward so the highest-priority valid requester wins last.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr} + (LNREQ + 1)'(k);
            if (w_scan >= (LNREQ + 1)'(NREQ)) begin
                w_scan = w_scan - (LNREQ + 1)'(NREQ);
            end
            if (i_req_valid[w_scan[LNREQ-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[LNREQ-1:0];
            end
        end
    end

    always_comb begin
        w_rr_inc = {1'b0, w_grant_idx} + (LNREQ + 1)'(1);
        if (w_rr_inc >= (LNREQ + 1)'(NREQ)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_rr_inc[LNREQ-1:0];
        end
    end

    always_comb begin
        w_used   = (AW + 2)'(r_count) + (AW + 2)'(r_s0_live) + (AW + 2)'(r_s1_live);
        w_credit = w_used < (AW + 2)'(FDEPTH);
        w_issue  = w_grant_found && w_credit && !i_flush && !i_reset;
    end

    always_comb begin
        o_mul_start = w_issue;
        o_req_ack   = '0;
        o_mul_sel   = '0;
        o_mul_rd    = '0;
        o_mul_hart  = '0;
        if (w_issue) begin
            o_req_ack[w_grant_idx] = 1'b1;
            o_mul_sel              = w_grant_idx;
            o_mul_rd               = i_req_rd[w_grant_idx*LNCOMMIT +: LNCOMMIT];
            o_mul_hart             = i_req_hart[w_grant_idx*HW +: HW];
        end
    end

    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        // Results reaching a squashed stage-1 slot belong to flushed ops and are dropped.
        w_push  = i_mul_valid && r_s1_live && !i_flush;
        w_pop   = !w_empty && i_wb_ack && !i_flush;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        o_wb_req       = !w_empty;
        o_wb_res       = r_mem_res[r_rptr[AW-1:0]];
        o_wb_rd        = r_mem_rd[r_rptr[AW-1:0]];
        o_wb_hart      = r_mem_hart[r_rptr[AW-1:0]];
        o_wb_exception = r_mem_exc[r_rptr[AW-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rr      <= '0;
            r_s0_live <= 1'b0;
            r_s0_exc  <= 1'b0;
            r_s1_live <= 1'b0;
            r_s1_exc  <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (i_flush) begin
            r_s0_live <= 1'b0;
            r_s1_live <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_s0_live <= w_issue;
            r_s0_exc  <= w_issue & i_mul_exception;
            r_s1_live <= r_s0_live;
            r_s1_exc  <= r_s0_exc;
            if (w_issue) begin
                r_rr <= w_rr_next;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_res[r_wptr[AW-1:0]]  <= i_mul_res;
            r_mem_rd[r_wptr[AW-1:0]]   <= i_mul_rd_out;
            r_mem_hart[r_wptr[AW-1:0]] <= i_mul_hart_out;
            r_mem_exc[r_wptr[AW-1:0]]  <= r_s1_exc;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!r_s1_live || i_mul_valid)
            else $error("fp_mul_sched: live stage-1 op without mul_valid");
            assert (!(w_push && w_full))
            else $error("fp_mul_sched: push into full result FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched: cycle model with a result scoreboard queue,
// a 2-cycle multiplier model, and directed latency/backpressure/flush/reset scenarios.
module tb_fp_mul_sched;

    localparam int NREQ   = 2;
    localparam int FDEPTH = 4;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  rd;
        logic        hart;
        logic        exc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [5:0]  rd_vec [2];
    logic [1:0]  hart_vec = 2'b10;
    logic [1:0]  exc_vec = '0;
    logic        flush = 1'b0;
    logic        wb_ack = 1'b0;

    logic [11:0] req_rd;
    logic [1:0]  req_ack;
    logic        mul_start;
    logic        mul_sel;
    logic [5:0]  mul_rd;
    logic        mul_hart;
    logic        mul_exc;
    logic        wb_req;
    logic [63:0] wb_res;
    logic [5:0]  wb_rd;
    logic        wb_hart;
    logic        wb_exc;

    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic        p1_sel = 1'b0, p1_h = 1'b0, p2_h = 1'b0;
    logic [5:0]  p1_rd = '0, p2_rd = '0;
    logic [63:0] p2_res = '0;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_start = 0;
    int          glog[$];
    int          rr_exp[4] = '{0, 1, 0, 1};

    ent_t        m_fifo[$];
    ent_t        m_e0, m_e1;
    logic        m_l0 = 1'b0, m_l1 = 1'b0;
    logic        m_rr = 1'b0;
    logic        m_scan, m_gi, m_gfound, m_issue;
    int          m_used;

    assign req_rd  = {rd_vec[1], rd_vec[0]};
    assign mul_exc = exc_vec[mul_sel];

    fp_mul_sched #(
        .RV(64), .LNCOMMIT(6), .NHART(1), .LNHART(1), .NREQ(NREQ), .LNREQ(1), .FDEPTH(FDEPTH)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .i_req_rd       (req_rd),
        .i_req_hart     (hart_vec),
        .o_req_ack      (req_ack),
        .o_mul_start    (mul_start),
        .o_mul_sel      (mul_sel),
        .o_mul_rd       (mul_rd),
        .o_mul_hart     (mul_hart),
        .i_mul_exception(mul_exc),
        .i_mul_valid    (p2_v),
        .i_mul_res      (p2_res),
        .i_mul_rd_out   (p2_rd),
        .i_mul_hart_out (p2_h),
        .i_flush        (flush),
        .o_wb_req       (wb_req),
        .o_wb_res       (wb_res),
        .o_wb_rd        (wb_rd),
        .o_wb_hart      (wb_hart),
        .o_wb_exception (wb_exc),
        .i_wb_ack       (wb_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkres(input logic sel, input logic [5:0] rd);
        return {32'hC0DE0000 | {31'd0, sel}, 26'd0, rd};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        exc_vec   = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Multiplier model: result and returned tag appear two cycles after start.
    always @(posedge clk) begin
        p1_v   <= mul_start;
        p1_sel <= mul_sel;
        p1_rd  <= mul_rd;
        p1_h   <= mul_hart;
        p2_v   <= p1_v;
        p2_res <= mkres(p1_sel, p1_rd);
        p2_rd  <= p1_rd;
        p2_h   <= p1_h;
    end

    // Cycle model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (reset) begin
            check_eq("rst_req_ack", 64'(req_ack), 64'd0);
            check_eq("rst_mul_start", 64'(mul_start), 64'd0);
            check_eq("rst_mul_sel", 64'(mul_sel), 64'd0);
            check_eq("rst_wb_req", 64'(wb_req), 64'd0);
            m_l0 = 1'b0;
            m_l1 = 1'b0;
            m_rr = 1'b0;
            m_fifo.delete();
        end else begin
            m_used   = int'(m_l0) + int'(m_l1) + m_fifo.size();
            m_gfound = 1'b0;
            m_gi     = 1'b0;
            for (int k = NREQ - 1; k >= 0; k--) begin
                m_scan = m_rr + 1'(k);
                if (req_valid[m_scan]) begin
                    m_gfound = 1'b1;
                    m_gi     = m_scan;
                end
            end
            m_issue = m_gfound && !flush && (m_used < FDEPTH);
            check_eq("req_ack", 64'(req_ack), m_issue ? (64'd1 << m_gi) : 64'd0);
            check_eq("mul_start", 64'(mul_start), 64'(m_issue));
            if (m_issue) begin
                check_eq("mul_sel", 64'(mul_sel), 64'(m_gi));
                check_eq("mul_rd", 64'(mul_rd), 64'(rd_vec[m_gi]));
                check_eq("mul_hart", 64'(mul_hart), 64'(hart_vec[m_gi]));
            end
            check_eq("wb_req", 64'(wb_req), 64'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                check_eq("wb_res", wb_res, m_fifo[0].res);
                check_eq("wb_rd", 64'(wb_rd), 64'(m_fifo[0].rd));
                check_eq("wb_hart", 64'(wb_hart), 64'(m_fifo[0].hart));
                check_eq("wb_exception", 64'(wb_exc), 64'(m_fifo[0].exc));
            end
            if (mul_start) begin
                n_start++;
                glog.push_back(int'(mul_sel));
            end
            if (flush) begin
                m_l0 = 1'b0;
                m_l1 = 1'b0;
                m_fifo.delete();
            end else begin
                if (m_fifo.size() != 0 && wb_ack) void'(m_fifo.pop_front());
                if (m_l1) m_fifo.push_back(m_e1);
                m_l1 = m_l0;
                m_e1 = m_e0;
                m_l0 = m_issue;
                if (m_issue) begin
                    m_e0.res  = mkres(m_gi, rd_vec[m_gi]);
                    m_e0.rd   = rd_vec[m_gi];
                    m_e0.hart = hart_vec[m_gi];
                    m_e0.exc  = exc_vec[m_gi];
                    m_rr      = m_gi + 1'b1;
                end
            end
        end
    end

    initial begin
        rd_vec[0] = '0;
        rd_vec[1] = '0;
        do_reset();

        // Single op: 3-cycle issue-to-writeback latency, acked head leaves next cycle.
        rd_vec[0] = 6'd5;
        wb_ack    = 1'b1;
        req_valid = 2'b01;
        #1;
        check_eq("single_ack", 64'(req_ack), 64'd1);
        check_eq("single_sel", 64'(mul_sel), 64'd0);
        tick();
        req_valid = '0;
        tick();
        check_eq("single_wb_t2", 64'(wb_req), 64'd0);
        tick();
        check_eq("single_wb_t3", 64'(wb_req), 64'd1);
        check_eq("single_rd_t3", 64'(wb_rd), 64'd5);
        tick();
        check_eq("single_wb_t4", 64'(wb_req), 64'd0);
        repeat (3) tick();

        // Round-robin alternation from rr=0.
        do_reset();
        rd_vec[0] = 6'd10;
        rd_vec[1] = 6'd20;
        wb_ack    = 1'b1;
        glog.delete();
        req_valid = 2'b11;
        repeat (4) tick();
        req_valid = '0;
        repeat (6) tick();
        check_eq("rr_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            check_eq("rr_order", 64'(glog[i]), 64'(rr_exp[i]));
        end

        // Backpressure: credits stop issue at FDEPTH, one pop frees exactly one issue.
        do_reset();
        rd_vec[0] = 6'd7;
        wb_ack    = 1'b0;
        n_start   = 0;
        req_valid = 2'b01;
        repeat (10) tick();
        check_eq("bp_issues", 64'(n_start), 64'd4);
        check_eq("bp_wb_req", 64'(wb_req), 64'd1);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        #1;
        check_eq("bp_reissue", 64'(mul_start), 64'd1);
        repeat (4) tick();
        check_eq("bp_issues_after", 64'(n_start), 64'd5);
        req_valid = '0;
        wb_ack    = 1'b1;
        repeat (8) tick();

        // Exception flag captured at issue and carried with its op.
        do_reset();
        wb_ack    = 1'b0;
        rd_vec[0] = 6'd3;
        exc_vec   = 2'b01;
        req_valid = 2'b01;
        tick();
        rd_vec[0] = 6'd4;
        exc_vec   = 2'b00;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check_eq("exc_first", 64'(wb_exc), 64'd1);
        wb_ack = 1'b1;
        tick();
        check_eq("exc_second_req", 64'(wb_req), 64'd1);
        check_eq("exc_second", 64'(wb_exc), 64'd0);
        repeat (3) tick();

        // Flush with two ops buffered and two in flight.
        do_reset();
        wb_ack    = 1'b0;
        rd_vec[0] = 6'd9;
        req_valid = 2'b01;
        repeat (4) tick();
        check_eq("fl_pre_wb_req", 64'(wb_req), 64'd1);
        flush     = 1'b1;
        wb_ack    = 1'b1;
        rd_vec[0] = 6'd11;
        #1;
        check_eq("fl_ack", 64'(req_ack), 64'd0);
        check_eq("fl_start", 64'(mul_start), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl_wb_req", 64'(wb_req), 64'd0);
        check_eq("fl_new_issue", 64'(mul_start), 64'd1);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Asynchronous reset in a push cycle, then a clean op.
        do_reset();
        wb_ack    = 1'b0;
        rd_vec[0] = 6'd21;
        req_valid = 2'b01;
        repeat (2) tick();
        req_valid = '0;
        tick();
        check_eq("ar_pre_wb_req", 64'(wb_req), 64'd1);
        req_valid = 2'b01;
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_wb_req", 64'(wb_req), 64'd0);
        check_eq("ar_ack", 64'(req_ack), 64'd0);
        check_eq("ar_start", 64'(mul_start), 64'd0);
        check_eq("ar_sel", 64'(mul_sel), 64'd0);
        tick();
        rd_vec[0] = 6'd33;
        reset     = 1'b0;
        #1;
        check_eq("ar_issue", 64'(mul_start), 64'd1);
        tick();
        req_valid = '0;
        tick();
        check_eq("ar_wb_t2", 64'(wb_req), 64'd0);
        tick();
        check_eq("ar_wb_t3", 64'(wb_req), 64'd1);
        check_eq("ar_rd_t3", 64'(wb_rd), 64'd33);
        wb_ack = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
